bcd_serial_addsub: RTL and testbench

//   Parametrised, digit-serial, signed (sign-magnitude) BCD adder/subtractor.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_serial_addsub_if.sv | 28 ++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_serial_addsub.sv | 192 +++++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial sign-magnitude BCD adder/subtractor.
package bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Nine's complement of one BCD digit.
  function automatic logic [BCD_W-1:0] nines(input logic [BCD_W-1:0] d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub.
interface bcd_serial_addsub_if #(parameter int unsigned DIGITS = 3);
  import bcd_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [BCD_W*DIGITS-1:0]   a_bcd;
  logic                      a_sign;
  logic [BCD_W*DIGITS-1:0]   b_bcd;
  logic                      b_sign;
  logic                      sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*DIGITS-1:0]   res_bcd;
  logic                      res_sign;
  logic                      overflow;
  logic                      err;

  modport master (
    output in_valid, a_bcd, a_sign, b_bcd, b_sign, sub, out_ready,
    input  in_ready, out_valid, res_bcd, res_sign, overflow, err
  );

  modport slave (
    input  in_valid, a_bcd, a_sign, b_bcd, b_sign, sub, out_ready,
    output in_ready, out_valid, res_bcd, res_sign, overflow, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: binary sum, +6 correction above 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] s,
  output logic             cout
);

  logic [BCD_W:0] bin_sum;

  // Binary add, then decimal-correct when the digit sum exceeds nine.
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    if (bin_sum > {1'b0, BCD_NINE}) begin
      s    = bin_sum[BCD_W-1:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = bin_sum[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial sign-magnitude BCD adder/subtractor, one digit per clock.
// Optional feature macro: BCD_INVALID_CHECK_EN (flags non-BCD operand digits on err).
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_addsub_if.slave  bus
);

  localparam int unsigned W  = BCD_W * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            eff_sub_q, eff_sub_d;
  logic            a_sign_q, a_sign_d;
  logic            sign_q, sign_d;
  logic            ovf_q, ovf_d;

  logic [BCD_W-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic [W-1:0]     res_shift;
  logic             last_digit;
  logic             in_ready_c, out_valid_c;

  // Single digit adder shared by ADD (operand digits) and FIX (ten's complement).
  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Adder operand selection and result shift-in of the new digit at the top.
  always_comb begin
    if (state_q == ST_FIX) begin
      add_a = nines(res_q[BCD_W-1:0]);
      add_b = '0;
    end else begin
      add_a = a_q[BCD_W-1:0];
      add_b = eff_sub_q ? nines(b_q[BCD_W-1:0]) : b_q[BCD_W-1:0];
    end
    add_cin    = carry_q;
    res_shift  = (res_q >> BCD_W) | (W'(add_s) << (W - BCD_W));
    last_digit = (cnt_q == CW'(DIGITS - 1));
  end

  // State and datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      eff_sub_q <= 1'b0;
      a_sign_q  <= 1'b0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      eff_sub_q <= eff_sub_d;
      a_sign_q  <= a_sign_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    eff_sub_d = eff_sub_q;
    a_sign_d  = a_sign_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d       = bus.a_bcd;
          b_d       = bus.b_bcd;
          a_sign_d  = bus.a_sign;
          eff_sub_d = bus.a_sign ^ bus.b_sign ^ bus.sub;
          carry_d   = bus.a_sign ^ bus.b_sign ^ bus.sub;
          cnt_d     = '0;
          sign_d    = 1'b0;
          ovf_d     = 1'b0;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> BCD_W;
        b_d     = b_q >> BCD_W;
        res_d   = res_shift;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          cnt_d = '0;
          if (!eff_sub_q || add_cout) begin
            // Plain add, or subtract with |A| >= |B|: magnitude is final.
            sign_d  = a_sign_q & (res_shift != '0);
            ovf_d   = ~eff_sub_q & add_cout;
            state_d = ST_DONE;
          end else begin
            // |A| < |B|: partial result is the complement of the answer.
            sign_d  = ~a_sign_q;
            ovf_d   = 1'b0;
            carry_d = 1'b1;
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        res_d   = res_shift;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          sign_d  = sign_q & (res_shift != '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_c  = (state_q == ST_IDLE);
    out_valid_c = (state_q == ST_DONE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.res_bcd   = res_q;
  assign bus.res_sign  = sign_q;
  assign bus.overflow  = ovf_q;

`ifdef BCD_INVALID_CHECK_EN
  logic err_q, err_d, bad_in;

  // Flag any operand digit above nine at accept time.
  always_comb begin
    bad_in = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((bus.a_bcd[i*BCD_W +: BCD_W] > BCD_NINE) ||
          (bus.b_bcd[i*BCD_W +: BCD_W] > BCD_NINE))
        bad_in = 1'b1;
    end
  end

  // Error flag captured on accept, cleared on result handshake.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && bus.in_valid)      err_d = bad_in;
    else if (state_q == ST_DONE && bus.out_ready) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=3): directed table,
// hand-written stall/reset sequences, randomized ops against an integer model.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef BCD_INVALID_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic         as;
    logic [W-1:0] b;
    logic         bs;
    logic         sb;
    logic [W-1:0] e_res;
    logic         e_sign;
    logic         e_ovf;
    logic         e_err;
    int           e_lat;
    bit           chk_res;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] x);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Signed-integer reference for sign-magnitude add/subtract.
  task automatic model(input logic [W-1:0] a, input logic as, input logic [W-1:0] b,
                       input logic bs, input logic sb, output logic [W-1:0] res,
                       output logic sign, output logic ovf, output int lat);
    int ma, mb, va, vb, r, mag;
    ma  = bcd2int(a);
    mb  = bcd2int(b);
    va  = as ? -ma : ma;
    vb  = bs ? -mb : mb;
    r   = sb ? va - vb : va + vb;
    mag = (r < 0) ? -r : r;
    ovf  = (mag >= 1000);
    res  = int2bcd(mag % 1000);
    sign = (r < 0) && ((mag % 1000) != 0);
    lat  = ((as ^ bs ^ sb) && (ma < mb)) ? 2 * DIGITS : DIGITS;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, ".in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a_bcd    = v.a;
    bus.a_sign   = v.as;
    bus.b_bcd    = v.b;
    bus.b_sign   = v.bs;
    bus.sub      = v.sb;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.out_valid) begin
      chk({tag, ".timeout"}, 0, 1);
    end else begin
      if (v.chk_res) begin
        chk({tag, ".latency"}, cyc, v.e_lat);
        chk({tag, ".res_bcd"}, int'(bus.res_bcd), int'(v.e_res));
        chk({tag, ".res_sign"}, int'(bus.res_sign), int'(v.e_sign));
        chk({tag, ".overflow"}, int'(bus.overflow), int'(v.e_ovf));
      end
      chk({tag, ".err"}, int'(bus.err), int'(v.e_err));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".post_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, ".post_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, ".post_err"}, int'(bus.err), 0);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    logic [W-1:0] m_res;
    logic m_sign, m_ovf;
    int m_lat;

    //          a       as    b       bs    sb    res     sign  ovf   err     lat chk
    tbl[0] = '{12'h123, 1'b0, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 1'b0, 1'b0,   3, 1'b1};
    tbl[1] = '{12'h999, 1'b0, 12'h001, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0,   3, 1'b1};
    tbl[2] = '{12'h123, 1'b0, 12'h456, 1'b0, 1'b1, 12'h333, 1'b1, 1'b0, 1'b0,   6, 1'b1};
    tbl[3] = '{12'h250, 1'b1, 12'h250, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0,   3, 1'b1};
    tbl[4] = '{12'h700, 1'b1, 12'h200, 1'b1, 1'b1, 12'h500, 1'b1, 1'b0, 1'b0,   3, 1'b1};
    tbl[5] = '{12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0,   3, 1'b1};
    tbl[6] = '{12'h001, 1'b1, 12'h999, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0, 1'b0,   6, 1'b1};
    tbl[7] = '{12'h500, 1'b0, 12'h500, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0,   3, 1'b1};
    tbl[8] = '{12'h999, 1'b1, 12'h999, 1'b1, 1'b0, 12'h998, 1'b1, 1'b1, 1'b0,   3, 1'b1};
    tbl[9] = '{12'h1A3, 1'b0, 12'h001, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, ERR_EN, 0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a_bcd     = '0;
    bus.a_sign    = 1'b0;
    bus.b_bcd     = '0;
    bus.b_sign    = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", int'(bus.in_ready), 1);
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.res_bcd", int'(bus.res_bcd), 0);
    chk("reset.res_sign", int'(bus.res_sign), 0);
    chk("reset.overflow", int'(bus.overflow), 0);
    chk("reset.err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Stall in DONE with in_valid pulsed: outputs hold, nothing accepted.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_bcd = 12'h123; bus.a_sign = 1'b0;
    bus.b_bcd = 12'h456; bus.b_sign = 1'b0; bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall.out_valid0", int'(bus.out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.in_valid = 1'b1;
        bus.a_bcd = 12'h888; bus.b_bcd = 12'h111; bus.sub = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("stall.c%0d.out_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("stall.c%0d.in_ready", c), int'(bus.in_ready), 0);
      chk($sformatf("stall.c%0d.res_bcd", c), int'(bus.res_bcd), 'h579);
      chk($sformatf("stall.c%0d.res_sign", c), int'(bus.res_sign), 0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("stall.release.in_ready", int'(bus.in_ready), 1);
    repeat (8) begin @(posedge clk); #1; end
    chk("stall.nothing_queued", int'(bus.out_valid), 0);

    // Reset pulse mid-ADD discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_bcd = 12'h999; bus.a_sign = 1'b0;
    bus.b_bcd = 12'h999; bus.b_sign = 1'b0; bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.busy", int'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.in_ready", int'(bus.in_ready), 1);
    chk("rst_mid.out_valid", int'(bus.out_valid), 0);
    chk("rst_mid.res_bcd", int'(bus.res_bcd), 0);
    chk("rst_mid.overflow", int'(bus.overflow), 0);
    chk("rst_mid.res_sign", int'(bus.res_sign), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("rst_mid.no_result", int'(bus.out_valid), 0);

    // Randomized operations against the integer model.
    for (int i = 0; i < 60; i++) begin
      v.a  = '0;
      v.b  = '0;
      for (int d = 0; d < DIGITS; d++) begin
        v.a[d*4 +: 4] = 4'($urandom_range(0, 9));
        v.b[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      v.as = 1'($urandom_range(0, 1));
      v.bs = 1'($urandom_range(0, 1));
      v.sb = 1'($urandom_range(0, 1));
      model(v.a, v.as, v.b, v.bs, v.sb, m_res, m_sign, m_ovf, m_lat);
      v.e_res   = m_res;
      v.e_sign  = m_sign;
      v.e_ovf   = m_ovf;
      v.e_err   = 1'b0;
      v.e_lat   = m_lat;
      v.chk_res = 1'b1;
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
